zpu_stack_engine: RTL and testbench

Command-driven initiator for the ZPU stack RAM, the dual-port write-first memory with 1-cycle read latency. It owns the stack pointer and turns PUSH/POP/LOADSP/STORESP/ADDSP/SETSP commands into RAM port transactions. Port B is used for reads; port A is used for writes and for the second operand read of ADDSP. It sits between the pipeline's stack-op stage and the stack RAM.

---
 rtl/zpu_stack_engine.sv | 223 ++++++++++++++++++++++
 tb/tb_zpu_stack_engine.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zpu_stack_engine.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : zpu_stack_engine                                             |
// | Purpose  : Stack-pointer owner that turns stack commands into RAM       |
// |            port transactions against the dual-port ZPU stack RAM.       |
// | Revision : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module zpu_stack_engine #(
   parameter int          ADDR_BITS   = 10,
   parameter logic [31:0] SP_INIT     = 32'h0000_0FF8,
   parameter logic [31:0] STACK_LIMIT = 32'h0000_0800
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [4:0]  cmd_offset,
   input  logic [31:0] cmd_data,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic [31:0] sp_out,
   output logic        err_overflow,
   output logic        err_underflow,
   output logic        err_illegal,
   output logic        ram_ena,
   output logic [3:0]  ram_wea,
   output logic [31:0] ram_addra,
   output logic [31:0] ram_dina,
   input  logic [31:0] ram_douta,
   output logic        ram_enb,
   output logic [31:0] ram_addrb,
   input  logic [31:0] ram_doutb
);

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_ISSUE = 2'd1;
   localparam logic [1:0] c_ST_RDATA = 2'd2;
   localparam logic [1:0] c_ST_WRITE = 2'd3;

   localparam logic [2:0] c_OP_NOP     = 3'd0;
   localparam logic [2:0] c_OP_PUSH    = 3'd1;
   localparam logic [2:0] c_OP_POP     = 3'd2;
   localparam logic [2:0] c_OP_LOADSP  = 3'd3;
   localparam logic [2:0] c_OP_STORESP = 3'd4;
   localparam logic [2:0] c_OP_ADDSP   = 3'd5;
   localparam logic [2:0] c_OP_SETSP   = 3'd6;
   localparam logic [2:0] c_OP_ILL     = 3'd7;

   if (ADDR_BITS < 1 || ADDR_BITS > 30) begin : g_bad_addr_bits
      $error("zpu_stack_engine: ADDR_BITS out of range");
   end

   logic [1:0]  r_state;
   logic [2:0]  r_op;
   logic [31:0] r_data;
   logic [31:0] r_off_addr;
   logic [31:0] r_sp;
   logic        r_rsp_valid;
   logic [31:0] r_rsp_data;
   logic        r_ovf;
   logic        r_udf;
   logic        r_ill;
   logic        r_ena;
   logic [3:0]  r_wea;
   logic [31:0] r_addra;
   logic [31:0] r_dina;
   logic        r_enb;
   logic [31:0] r_addrb;

   logic [31:0] w_sp_dec;
   logic [31:0] w_sp_inc;
   logic [31:0] w_cmd_off_addr;
   logic [31:0] w_sum;

   assign w_sp_dec       = r_sp - 32'd4;
   assign w_sp_inc       = r_sp + 32'd4;
   assign w_cmd_off_addr = r_sp + {25'd0, cmd_offset, 2'b00};
   assign w_sum          = ram_douta + ram_doutb;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= c_ST_IDLE;
         r_op        <= c_OP_NOP;
         r_data      <= 32'd0;
         r_off_addr  <= 32'd0;
         r_sp        <= SP_INIT;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= 32'd0;
         r_ovf       <= 1'b0;
         r_udf       <= 1'b0;
         r_ill       <= 1'b0;
         r_ena       <= 1'b0;
         r_wea       <= 4'h0;
         r_addra     <= 32'd0;
         r_dina      <= 32'd0;
         r_enb       <= 1'b0;
         r_addrb     <= 32'd0;
      end else begin
         r_ena       <= 1'b0;
         r_wea       <= 4'h0;
         r_enb       <= 1'b0;
         r_rsp_valid <= 1'b0;
         case (r_state)
            c_ST_IDLE: begin
               if (cmd_valid) begin
                  r_op       <= cmd_op;
                  r_data     <= cmd_data;
                  r_off_addr <= w_cmd_off_addr;
                  case (cmd_op)
                     c_OP_PUSH: begin
                        r_ena   <= 1'b1;
                        r_wea   <= 4'hF;
                        r_addra <= w_sp_dec;
                        r_dina  <= cmd_data;
                        r_state <= c_ST_WRITE;
                     end
                     c_OP_POP, c_OP_STORESP: begin
                        r_enb   <= 1'b1;
                        r_addrb <= r_sp;
                        r_state <= c_ST_ISSUE;
                     end
                     c_OP_LOADSP: begin
                        r_enb   <= 1'b1;
                        r_addrb <= w_cmd_off_addr;
                        r_state <= c_ST_ISSUE;
                     end
                     c_OP_ADDSP: begin
                        r_enb   <= 1'b1;
                        r_addrb <= w_cmd_off_addr;
                        r_ena   <= 1'b1;
                        r_addra <= r_sp;
                        r_state <= c_ST_ISSUE;
                     end
                     default: r_state <= c_ST_WRITE;
                  endcase
               end
            end
            c_ST_ISSUE: r_state <= c_ST_RDATA;
            c_ST_RDATA: begin
               case (r_op)
                  c_OP_POP: begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_data  <= ram_doutb;
                     r_sp        <= w_sp_inc;
                     if (w_sp_inc > SP_INIT) r_udf <= 1'b1;
                     r_state     <= c_ST_IDLE;
                  end
                  c_OP_LOADSP: begin
                     r_ena   <= 1'b1;
                     r_wea   <= 4'hF;
                     r_addra <= w_sp_dec;
                     r_dina  <= ram_doutb;
                     r_state <= c_ST_WRITE;
                  end
                  c_OP_STORESP: begin
                     r_ena   <= 1'b1;
                     r_wea   <= 4'hF;
                     r_addra <= r_off_addr + 32'd4;
                     r_dina  <= ram_doutb;
                     r_state <= c_ST_WRITE;
                  end
                  c_OP_ADDSP: begin
                     r_ena   <= 1'b1;
                     r_wea   <= 4'hF;
                     r_addra <= r_sp;
                     r_dina  <= w_sum;
                     r_state <= c_ST_WRITE;
                  end
                  default: r_state <= c_ST_IDLE;
               endcase
            end
            c_ST_WRITE: begin
               r_state <= c_ST_IDLE;
               // r_dina still holds the word written in this cycle; it is the response
               case (r_op)
                  c_OP_PUSH: begin
                     r_sp <= w_sp_dec;
                     if (w_sp_dec < STACK_LIMIT) r_ovf <= 1'b1;
                  end
                  c_OP_LOADSP: begin
                     r_sp        <= w_sp_dec;
                     if (w_sp_dec < STACK_LIMIT) r_ovf <= 1'b1;
                     r_rsp_valid <= 1'b1;
                     r_rsp_data  <= r_dina;
                  end
                  c_OP_STORESP: begin
                     r_sp        <= w_sp_inc;
                     if (w_sp_inc > SP_INIT) r_udf <= 1'b1;
                     r_rsp_valid <= 1'b1;
                     r_rsp_data  <= r_dina;
                  end
                  c_OP_ADDSP: begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_data  <= r_dina;
                  end
                  c_OP_SETSP: r_sp  <= r_data & ~32'd3;
                  c_OP_ILL:   r_ill <= 1'b1;
                  default: ;
               endcase
            end
            default: r_state <= c_ST_IDLE;
         endcase
      end
   end

   assign cmd_ready     = (r_state == c_ST_IDLE) && !reset;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_data      = r_rsp_data;
   assign sp_out        = r_sp;
   assign err_overflow  = r_ovf;
   assign err_underflow = r_udf;
   assign err_illegal   = r_ill;
   assign ram_ena       = r_ena;
   assign ram_wea       = r_wea;
   assign ram_addra     = r_addra;
   assign ram_dina      = r_dina;
   assign ram_enb       = r_enb;
   assign ram_addrb     = r_addrb;

endmodule
`default_nettype wire

// File: tb/tb_zpu_stack_engine.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_zpu_stack_engine                                          |
// | Purpose  : Directed plus randomized bench with a stack-level model.     |
// | Revision : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_zpu_stack_engine;

   localparam logic [31:0] SP_INIT     = 32'h0000_0FF8;
   localparam logic [31:0] STACK_LIMIT = 32'h0000_0800;

   localparam logic [2:0] c_NOP = 3'd0, c_PUSH = 3'd1, c_POP = 3'd2, c_LOADSP = 3'd3;
   localparam logic [2:0] c_STORESP = 3'd4, c_ADDSP = 3'd5, c_SETSP = 3'd6, c_ILL = 3'd7;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_op = 3'd0;
   logic [4:0]  cmd_offset = 5'd0;
   logic [31:0] cmd_data = 32'd0;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic [31:0] sp_out;
   logic        err_overflow, err_underflow, err_illegal;
   logic        ram_ena, ram_enb;
   logic [3:0]  ram_wea;
   logic [31:0] ram_addra, ram_dina, ram_addrb;
   logic [31:0] ram_douta = 32'd0;
   logic [31:0] ram_doutb = 32'd0;

   int n_vec = 0;
   int n_bad = 0;

   logic [31:0] ram_mem [1024];
   logic [31:0] ram_tmp;

   logic [31:0] m_mem [1024];
   logic [31:0] m_sp;
   logic        m_ovf, m_udf, m_ill;

   zpu_stack_engine #(
      .ADDR_BITS  (10),
      .SP_INIT    (SP_INIT),
      .STACK_LIMIT(STACK_LIMIT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_offset   (cmd_offset),
      .cmd_data     (cmd_data),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .sp_out       (sp_out),
      .err_overflow (err_overflow),
      .err_underflow(err_underflow),
      .err_illegal  (err_illegal),
      .ram_ena      (ram_ena),
      .ram_wea      (ram_wea),
      .ram_addra    (ram_addra),
      .ram_dina     (ram_dina),
      .ram_douta    (ram_douta),
      .ram_enb      (ram_enb),
      .ram_addrb    (ram_addrb),
      .ram_doutb    (ram_doutb)
   );

   always #5 clk = ~clk;

   // Write-first dual-port stack RAM, one cycle read latency
   always @(posedge clk) begin
      if (ram_ena) begin
         ram_tmp = ram_mem[ram_addra[11:2]];
         for (int b = 0; b < 4; b++)
            if (ram_wea[b]) ram_tmp[8*b +: 8] = ram_dina[8*b +: 8];
         ram_mem[ram_addra[11:2]] <= ram_tmp;
         ram_douta <= ram_tmp;
      end
      if (ram_enb) ram_doutb <= ram_mem[ram_addrb[11:2]];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rd(input logic [31:0] a);
      logic [9:0] i;
      i = a[11:2];
      return m_mem[i];
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      check("rst_ready", {31'd0, cmd_ready}, 32'd0);
      check("rst_sp", sp_out, SP_INIT);
      check("rst_ram_en", {30'd0, ram_ena, ram_enb}, 32'd0);
      check("rst_wea", {28'd0, ram_wea}, 32'd0);
      check("rst_addr", ram_addra | ram_addrb | ram_dina, 32'd0);
      check("rst_rsp", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_err", {29'd0, err_overflow, err_underflow, err_illegal}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      m_sp = SP_INIT;
      m_ovf = 1'b0; m_udf = 1'b0; m_ill = 1'b0;
   endtask

   // Issue one command, observe the port activity for its lifetime and
   // compare everything against the stack-level model
   task automatic do_cmd(input logic [2:0] op, input logic [4:0] off, input logic [31:0] d);
      logic [31:0] off_addr, e_sp, e_rd, e_wr_a, e_wr_d, e_rsp;
      int e_rdy, e_wr_k, e_rsp_k;
      bit e_rdb, e_rda;
      int rdy_k, n_wr, wr_k, n_rdb, n_rda, n_rsp, rsp_k;
      logic [31:0] wr_a, wr_d, rdb_a, rda_a, rsp_d;

      off_addr = m_sp + 32'(off) * 32'd4;
      e_sp = m_sp; e_rd = 32'd0; e_wr_a = 32'd0; e_wr_d = 32'd0; e_rsp = 32'd0;
      e_rdy = 2; e_wr_k = 0; e_rsp_k = 0; e_rdb = 1'b0; e_rda = 1'b0;
      case (op)
         c_PUSH: begin
            e_wr_k = 1; e_wr_a = m_sp - 32'd4; e_wr_d = d; e_sp = m_sp - 32'd4;
         end
         c_POP: begin
            e_rdb = 1'b1; e_rd = m_sp; e_rsp = rd(m_sp); e_rsp_k = 3; e_rdy = 3;
            e_sp = m_sp + 32'd4;
         end
         c_LOADSP: begin
            e_rdb = 1'b1; e_rd = off_addr; e_rsp = rd(off_addr); e_rsp_k = 4; e_rdy = 4;
            e_wr_k = 3; e_wr_a = m_sp - 32'd4; e_wr_d = e_rsp; e_sp = m_sp - 32'd4;
         end
         c_STORESP: begin
            e_rdb = 1'b1; e_rd = m_sp; e_rsp = rd(m_sp); e_rsp_k = 4; e_rdy = 4;
            e_wr_k = 3; e_wr_a = off_addr + 32'd4; e_wr_d = e_rsp; e_sp = m_sp + 32'd4;
         end
         c_ADDSP: begin
            e_rdb = 1'b1; e_rda = 1'b1; e_rd = off_addr;
            e_rsp = rd(m_sp) + rd(off_addr); e_rsp_k = 4; e_rdy = 4;
            e_wr_k = 3; e_wr_a = m_sp; e_wr_d = e_rsp;
         end
         c_SETSP: e_sp = d & ~32'd3;
         default: ;
      endcase

      @(negedge clk);
      check("ready_idle", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1; cmd_op = op; cmd_offset = off; cmd_data = d;
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_op = 3'd0; cmd_offset = 5'd0; cmd_data = $urandom;

      rdy_k = 0; n_wr = 0; wr_k = 0; n_rdb = 0; n_rda = 0; n_rsp = 0; rsp_k = 0;
      wr_a = 0; wr_d = 0; rdb_a = 0; rda_a = 0; rsp_d = 0;
      for (int k = 1; k <= 6; k++) begin
         if (k > 1) begin @(posedge clk); #1; end
         if (ram_ena && ram_wea != 4'h0) begin
            n_wr++; wr_k = k; wr_a = ram_addra; wr_d = ram_dina;
            if (ram_wea != 4'hF) n_wr += 10;
         end
         if (ram_ena && ram_wea == 4'h0) begin n_rda++; rda_a = ram_addra; end
         if (ram_enb) begin n_rdb++; rdb_a = ram_addrb; end
         if (rsp_valid) begin n_rsp++; rsp_k = k; rsp_d = rsp_data; end
         if (cmd_ready) begin rdy_k = k; break; end
      end

      check("ready_latency", rdy_k, e_rdy);
      check("write_count", n_wr, (e_wr_k != 0) ? 1 : 0);
      if (e_wr_k != 0) begin
         check("write_cycle", wr_k, e_wr_k);
         check("write_addr", wr_a, e_wr_a);
         check("write_data", wr_d, e_wr_d);
      end
      check("portb_reads", n_rdb, e_rdb ? 1 : 0);
      if (e_rdb) check("portb_addr", rdb_a, e_rd);
      check("porta_reads", n_rda, e_rda ? 1 : 0);
      if (e_rda) check("porta_addr", rda_a, m_sp);
      check("rsp_count", n_rsp, (e_rsp_k != 0) ? 1 : 0);
      if (e_rsp_k != 0) begin
         check("rsp_cycle", rsp_k, e_rsp_k);
         check("rsp_data", rsp_d, e_rsp);
      end

      if ((op == c_PUSH || op == c_LOADSP) && e_sp < STACK_LIMIT) m_ovf = 1'b1;
      if ((op == c_POP || op == c_STORESP) && e_sp > SP_INIT) m_udf = 1'b1;
      if (op == c_ILL) m_ill = 1'b1;
      if (e_wr_k != 0) m_mem[e_wr_a[11:2]] = e_wr_d;
      m_sp = e_sp;

      check("sp_out", sp_out, m_sp);
      check("err_flags", {29'd0, err_overflow, err_underflow, err_illegal},
            {29'd0, m_ovf, m_udf, m_ill});
      if (e_wr_k != 0) check("ram_content", ram_mem[e_wr_a[11:2]], e_wr_d);
   endtask

   initial begin
      int n_rsp_abort;
      logic [2:0] rop;
      logic [31:0] rdat;

      for (int i = 0; i < 1024; i++) begin
         ram_mem[i] = 32'd0;
         m_mem[i]   = 32'd0;
      end
      m_sp = SP_INIT; m_ovf = 1'b0; m_udf = 1'b0; m_ill = 1'b0;

      do_reset();
      do_cmd(c_PUSH, 5'd0, 32'hDEADBEEF);

      do_reset();
      do_cmd(c_PUSH, 5'd0, 32'h11);
      do_cmd(c_PUSH, 5'd0, 32'h22);
      do_cmd(c_POP, 5'd0, 32'd0);
      do_cmd(c_POP, 5'd0, 32'd0);

      do_reset();
      do_cmd(c_PUSH, 5'd0, 32'd1);
      do_cmd(c_PUSH, 5'd0, 32'd2);
      do_cmd(c_PUSH, 5'd0, 32'd3);
      do_cmd(c_LOADSP, 5'd2, 32'd0);

      do_reset();
      do_cmd(c_PUSH, 5'd0, 32'h7FFFFFFF);
      do_cmd(c_PUSH, 5'd0, 32'h1);
      do_cmd(c_ADDSP, 5'd1, 32'd0);
      do_cmd(c_PUSH, 5'd0, 32'hFFFFFFFF);
      do_cmd(c_PUSH, 5'd0, 32'h2);
      do_cmd(c_ADDSP, 5'd1, 32'd0);

      do_reset();
      do_cmd(c_PUSH, 5'd0, 32'd9);
      do_cmd(c_PUSH, 5'd0, 32'd5);
      do_cmd(c_STORESP, 5'd0, 32'd0);
      do_cmd(c_POP, 5'd0, 32'd0);
      do_cmd(c_POP, 5'd0, 32'd0);

      // POP aborted by reset in its issue cycle
      do_reset();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = c_POP; cmd_offset = 5'd0;
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_op = 3'd0;
      check("abort_enb_before", {31'd0, ram_enb}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort_enb_after", {31'd0, ram_enb}, 32'd0);
      check("abort_sp", sp_out, SP_INIT);
      @(negedge clk);
      reset = 1'b0;
      n_rsp_abort = 0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         if (rsp_valid || ram_ena || ram_enb) n_rsp_abort++;
      end
      check("abort_no_activity", n_rsp_abort, 0);
      check("abort_ready", {31'd0, cmd_ready}, 32'd1);

      do_reset();
      do_cmd(c_SETSP, 5'd0, 32'h0000_0806);
      do_cmd(c_PUSH, 5'd0, 32'hA5A5A5A5);
      do_cmd(c_PUSH, 5'd0, 32'h5A5A5A5A);
      do_cmd(c_ILL, 5'd3, 32'd0);
      do_cmd(c_NOP, 5'd0, 32'd0);

      do_reset();
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 49) == 0) do_reset();
         rop  = 3'($urandom_range(0, 7));
         rdat = $urandom;
         if (rop == c_SETSP && $urandom_range(0, 3) != 0)
            rdat = 32'($urandom_range(32'h800, 32'hFFF));
         do_cmd(rop, 5'($urandom_range(0, 31)), rdat);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
